// File: rtl/updown_counter_n_pkg.sv
// Shared types for the up/down counter: FSM state encodings and datapath op codes.
package counter_pkg;

    typedef enum logic [2:0] {
        INICIO     = 3'd0,
        ESPERA     = 3'd1,
        VERIFICA   = 3'd2,
        INC        = 3'd3,
        ESPERA_INC = 3'd4,
        DEC        = 3'd5,
        ESPERA_DEC = 3'd6
    } state_t;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_DEC = 1'b1;

endpackage

// File: rtl/updown_counter_n_if.sv
// Button/mode inputs and counter outputs of updown_counter_n.
// The master side drives the buttons; the slave side is the counter itself.
interface updown_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             u;
    logic             d;
    logic             wrap;
    logic [WIDTH-1:0] count;
    logic             z;
    logic             m;

    modport master (output u, output d, output wrap, input count, input z, input m);
    modport slave  (input u, input d, input wrap, output count, output z, output m);
endinterface

// File: rtl/updown_counter_n_datapath.sv
// Counter register with clear/load and saturating or wrapping step arithmetic.
module counter_datapath
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op,
    input  logic             c_clr,
    input  logic             c_ld,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             z,
    output logic             m
);
    // One extra bit keeps count+STEP and count+MAX_VAL+1 free of overflow.
    localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH:0]   cur_ext, sum_ext;

    always_comb begin
        cur_ext  = {1'b0, count_q};
        sum_ext  = cur_ext + STEP_EXT;
        step_val = count_q;
        if (op == OP_INC) begin
            if (sum_ext > MAX_EXT) begin
                step_val = wrap ? WIDTH'(sum_ext - MOD_EXT) : WIDTH'(MAX_EXT);
            end else begin
                step_val = WIDTH'(sum_ext);
            end
        end else begin
            if (cur_ext < STEP_EXT) begin
                step_val = wrap ? WIDTH'(cur_ext + MOD_EXT - STEP_EXT) : '0;
            end else begin
                step_val = WIDTH'(cur_ext - STEP_EXT);
            end
        end

        count_d = count_q;
        if (c_clr) begin
            count_d = '0;
        end else if (c_ld) begin
            count_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign z     = (count_q == '0);
    assign m     = (count_q == WIDTH'(MAX_VAL));
endmodule

// File: rtl/updown_counter_n.sv
// Button-driven up/down counter FSM; the datapath lives in counter_datapath.
// Define UPDOWN_AUTO_REPEAT_EN to enable auto-repeat while a button is held.
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int MAX_VAL       = 2**WIDTH - 1,
    parameter int STEP          = 1,
    parameter int REPEAT_CYCLES = 16
) (
    input logic               clk,
    input logic               reset,
    updown_counter_n_if.slave bus
);
    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 ||
        STEP < 1 || STEP > MAX_VAL || REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("updown_counter_n: illegal parameter combination");
    end

    state_t state_q, state_d;
    logic   c_clr_q, c_clr_d;
    logic   c_ld_q, c_ld_d;
    logic   op_q, op_d;
    logic   wrap_q, wrap_d;

`ifdef UPDOWN_AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_CYCLES);
    // The INC/DEC cycle itself counts as one held cycle, hence the -2.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYCLES - 2);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wrap_d  = wrap_q;
`ifdef UPDOWN_AUTO_REPEAT_EN
        hold_d  = '0;
`endif
        case (state_q)
            INICIO:   state_d = ESPERA;
            ESPERA:   state_d = VERIFICA;
            VERIFICA: begin
                wrap_d = bus.wrap;
                if (bus.u && bus.d) begin
                    state_d = ESPERA;
                end else if (bus.u) begin
                    if (bus.wrap || !bus.m) begin
                        state_d = INC;
                        op_d    = OP_INC;
                    end
                end else if (bus.d) begin
                    if (bus.wrap || !bus.z) begin
                        state_d = DEC;
                        op_d    = OP_DEC;
                    end
                end
            end
            INC:      state_d = ESPERA_INC;
            DEC:      state_d = ESPERA_DEC;
            ESPERA_INC: begin
                if (!bus.u) begin
                    state_d = VERIFICA;
                end
`ifdef UPDOWN_AUTO_REPEAT_EN
                else begin
                    hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
                    if (hold_q == HOLD_LAST && (wrap_q || !bus.m)) begin
                        state_d = INC;
                    end
                end
`endif
            end
            ESPERA_DEC: begin
                if (!bus.d) begin
                    state_d = VERIFICA;
                end
`ifdef UPDOWN_AUTO_REPEAT_EN
                else begin
                    hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
                    if (hold_q == HOLD_LAST && (wrap_q || !bus.z)) begin
                        state_d = DEC;
                    end
                end
`endif
            end
            default:  state_d = INICIO;
        endcase

        // Clear is aligned with ESPERA so count is zero when ESPERA exits;
        // load follows INC/DEC by one cycle, giving the two-edge press latency.
        c_clr_d = (state_d == ESPERA);
        c_ld_d  = (state_q == INC) || (state_q == DEC);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INICIO;
            c_clr_q <= 1'b0;
            c_ld_q  <= 1'b0;
            op_q    <= OP_INC;
            wrap_q  <= 1'b0;
`ifdef UPDOWN_AUTO_REPEAT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_clr_q <= c_clr_d;
            c_ld_q  <= c_ld_d;
            op_q    <= op_d;
            wrap_q  <= wrap_d;
`ifdef UPDOWN_AUTO_REPEAT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    counter_datapath #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .op    (op_q),
        .c_clr (c_clr_q),
        .c_ld  (c_ld_q),
        .wrap  (wrap_q),
        .count (bus.count),
        .z     (bus.z),
        .m     (bus.m)
    );
endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (>=2).
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1, upper count bound (1..2**WIDTH-1).
REQ-003 The block SHALL have parameter STEP, default 1, increment/decrement amount (1..MAX_VAL).
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 16, hold time before auto-repeat (>=2; used only with AUTO_REPEAT_EN).
REQ-005 The block SHALL have a port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have a port reset, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have a port u, input, 1, up button, level, pre-synchronised.
REQ-008 The block SHALL have a port d, input, 1, down button, level, pre-synchronised.
REQ-009 The block SHALL have a port wrap, input, 1, mode: 0 saturate, 1 wrap-around; sampled in VERIFICA.
REQ-010 The block SHALL have a port count, output, WIDTH, registered counter value.
REQ-011 The block SHALL have a port z, output, 1, combinational flag, count==0.
REQ-012 The block SHALL have a port m, output, 1, combinational flag, count==MAX_VAL.

Function
REQ-013 The FSM SHALL use states INICIO, ESPERA, VERIFICA, INC, ESPERA_INC, DEC, ESPERA_DEC.
REQ-014 The FSM SHALL go INICIO->ESPERA->VERIFICA unconditionally, and ESPERA SHALL assert clear so that count=0 on exit.
REQ-015 From VERIFICA, u&~d SHALL go to INC, except when wrap=0 and m=1, where the FSM stays in VERIFICA.
REQ-016 From VERIFICA, d&~u SHALL go to DEC, except when wrap=0 and z=1, where the FSM stays in VERIFICA.
REQ-017 From VERIFICA, u&d SHALL go to ESPERA (clear); otherwise the FSM SHALL stay in VERIFICA.
REQ-018 INC and DEC SHALL each perform exactly one load, then move to ESPERA_INC or ESPERA_DEC respectively.
REQ-019 ESPERA_INC SHALL return to VERIFICA when u=0, and ESPERA_DEC SHALL return to VERIFICA when d=0; otherwise each SHALL hold.
REQ-020 Latency: u sampled high in VERIFICA at edge N SHALL produce the updated count visible after edge N+2.
REQ-021 Saturate increment (wrap=0) SHALL compute count = min(count+STEP, MAX_VAL).
REQ-022 Saturate decrement (wrap=0) SHALL compute count = max(count-STEP, 0).
REQ-023 Wrap increment (wrap=1) SHALL compute count = (count+STEP) mod (MAX_VAL+1).
REQ-024 Wrap decrement (wrap=1) SHALL compute count = count-STEP+MAX_VAL+1 when count<STEP, else count-STEP.
REQ-025 All arithmetic SHALL be done in WIDTH+1 bits with no intermediate overflow, and count SHALL never exceed MAX_VAL.
REQ-026 A change of wrap while in INC or DEC SHALL not affect the load in progress; the value latched in VERIFICA SHALL be used.
REQ-027 Unreachable state encodings SHALL recover to INICIO on the next edge.

Reset
REQ-028 reset=0 at a rising edge SHALL force state INICIO and count=0, regardless of state, including mid-INC or mid-DEC.
REQ-029 After reset deasserts, the FSM SHALL reach VERIFICA on the second edge with count=0, z=1 and m=(MAX_VAL==0), which is always 0.

Configuration
REQ-030 With macro UPDOWN_AUTO_REPEAT_EN defined, a hold counter SHALL run in ESPERA_INC/ESPERA_DEC; after REPEAT_CYCLES consecutive cycles of the button held, the FSM SHALL re-enter INC/DEC (boundary blocking per REQ-015/016 still applies), and the hold counter SHALL clear on every entry.
REQ-031 Without UPDOWN_AUTO_REPEAT_EN, the block SHALL perform one step per press, the hold counter SHALL be absent, and REPEAT_CYCLES SHALL be ignored.

Structure
REQ-032 Package counter_pkg SHALL hold the 3-bit state encodings and the op constants (OP_INC=0, OP_DEC=1).
REQ-033 The datapath SHALL be a sub-module counter_datapath (inputs op, c_clr, c_ld, wrap; outputs count, z, m), and the FSM SHALL remain in updown_counter_n.

Verification
REQ-034 Reset scenario (WIDTH=4, MAX_VAL=9, STEP=2): reset low 3 cycles then high -> count=0, z=1, VERIFICA after 2 edges.
REQ-035 Saturation scenario: wrap=0, five presses of u from 0 -> 2,4,6,8,9; a sixth press -> stays 9, FSM stays in VERIFICA.
REQ-036 Wrap scenario: wrap=1, count=8, press u -> 0; press d -> 8; from count=1, press d -> 9.
REQ-037 Hold scenario: u held 50 cycles without the macro -> exactly one step; with the macro (REPEAT_CYCLES=16) -> 1+3=4 steps.
REQ-038 Simultaneous-press scenario: u&d pressed at count=6 -> ESPERA, count=0 next edge; reset=0 during INC -> count=0, no load.
